tlb_l2_miss_ctrl: RTL and testbench
===================================

Name: tlb_l2_miss_ctrl

Overview:
Sequencer between the L1 TLB miss path and the set-associative L2 TLB with hash-rehash lookup.
- Accepts one L1 miss at a time.
- Drives the L2 lookup port across up to three hash probes, one per cycle.
- On L2 miss, issues a page-table-walk request and waits for the walk to complete.
- Returns the resulting PTE and page size to the L1 TLB.
- Drives the L2's ptw_active input so that hash counters freeze while a walk is in progress.

Parameters:
ASID_WIDTH, 1, ASID width.
VLEN, 64, virtual address width.
PTW_TIMEOUT, 255, cycles allowed in PTW_WAIT before an error response; must be ≥1.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  SFENCE.VMA flush, same cycle as the L2 TLB flush
req_valid_i  in  1  L1 miss request
req_ready_o  out  1  request accepted when high with req_valid_i
req_vaddr_i  in  VLEN  miss virtual address
req_asid_i  in  ASID_WIDTH  miss ASID
l2_access_o  out  1  L2 lookup strobe
l2_vaddr_o  out  VLEN  latched vaddr to L2
l2_asid_o  out  ASID_WIDTH  latched ASID to L2
l2_hit_i  in  1  L2 hit
l2_all_checked_i  in  1  L2 probe sequence finished
l2_content_i  in  64  L2 PTE
l2_is_2M_i  in  1  L2 2 MiB page
l2_is_1G_i  in  1  L2 1 GiB page
ptw_active_o  out  1  walk in progress; drives the L2 ptw_active_i
ptw_valid_o  out  1  walk request
ptw_ready_i  in  1  walker accepts the request
ptw_vaddr_o  out  VLEN  walk vaddr
ptw_asid_o  out  ASID_WIDTH  walk ASID
ptw_done_i  in  1  walk finished (1-cycle pulse)
ptw_error_i  in  1  walk fault, valid with done
ptw_content_i  in  64  walked PTE
ptw_is_2M_i  in  1  walked 2 MiB page
ptw_is_1G_i  in  1  walked 1 GiB page
rsp_valid_o  out  1  response pulse
rsp_content_o  out  64  PTE
rsp_is_2M_o  out  1  2 MiB page
rsp_is_1G_o  out  1  1 GiB page
rsp_error_o  out  1  walk fault or timeout

Behaviour:
- States: IDLE, LOOKUP, PTW_REQ, PTW_WAIT, DRAIN, RESP. Reset state IDLE; every output and the internal vaddr/ASID/PTE/size registers reset to 0.
- IDLE:
  - req_ready_o = !flush_i.
  - On handshake, latch vaddr/ASID and go to LOOKUP.
- LOOKUP:
  - l2_access_o = 1 every cycle; l2_vaddr_o/l2_asid_o come from the latched registers.
  - l2_hit_i → capture l2_content_i and sizes with rsp_error = 0, go to RESP.
  - l2_all_checked_i && !l2_hit_i → go to PTW_REQ.
  - A hit takes precedence over all_checked.
  - LOOKUP lasts 1–3 cycles.
- PTW_REQ:
  - ptw_valid_o = 1 and ptw_active_o = 1.
  - On ptw_ready_i, load the timeout counter with 0 and go to PTW_WAIT.
- PTW_WAIT:
  - ptw_active_o = 1; the counter increments each cycle.
  - ptw_done_i → capture ptw_content_i, sizes and ptw_error_i, go to RESP.
  - If the counter reaches PTW_TIMEOUT-1 without done → go to RESP with content 0 and rsp_error_o = 1, then pass through DRAIN semantics: a late done is ignored.
  - Done arriving on the timeout cycle: done wins.
- RESP: rsp_valid_o = 1 for exactly one cycle, with rsp_* from the registers; then go to IDLE. Outputs hold their values until the next RESP.
- Latency, with acceptance in cycle T and a hit on probe k (0..2): rsp_valid_o in cycle T+2+k.
- Full miss: ptw_valid_o first asserted in cycle T+4.
- Flush:
  - In IDLE, LOOKUP, PTW_REQ or RESP → IDLE next cycle, no response. In PTW_REQ, the request is withdrawn; the walker must tolerate this under flush.
  - In PTW_WAIT → DRAIN (ptw_active_o stays 1) until ptw_done_i, then IDLE with no response.
  - A flush coinciding with ptw_done_i in PTW_WAIT → IDLE, result dropped.
- Timeout is disabled in DRAIN.
- Only one request is outstanding at a time; req_ready_o = 0 outside IDLE.
- Reset mid-operation returns to IDLE immediately, with no response.

Optional Feature:
TLB_L2_MISS_CTRL_PERF_EN:
- When defined, adds three outputs: l2_hit_cnt_o[31:0], l2_miss_cnt_o[31:0] and ptw_timeout_cnt_o[15:0].
- Each counter increments on the corresponding LOOKUP→RESP, LOOKUP→PTW_REQ or timeout transition, saturates at all-ones, and is reset only by rst_ni (not by flush).
- When not defined, the ports and counters are absent.

Test Plan:
- Accept vaddr 0x40201000, ASID 1; L2 hits on probe 0 with PTE 0xCF → rsp_valid_o at T+2, content 0xCF, is_2M = is_1G = error = 0.
- L2 hits on probe 2 with l2_is_1G_i = 1 → exactly three l2_access_o cycles, rsp_valid_o at T+4, rsp_is_1G_o = 1.
- Full miss; walker ready after 2 cycles and done after 5 with PTE 0x1001, is_2M = 1 → ptw_active_o high from T+4 through done, rsp_content_o = 0x1001, rsp_is_2M_o = 1.
- PTW_TIMEOUT = 4 and no done → rsp_valid_o with rsp_error_o = 1 four cycles after the ptw handshake; a later done produces no second response.
- flush_i pulsed in PTW_WAIT, then done 3 cycles later → no rsp_valid_o, req_ready_o rises the cycle after done.
- Assert rst_ni low during LOOKUP → all outputs 0 immediately; after release a new request completes normally.

Source files
------------

// File: rtl/tlb_l2_miss_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tlb_l2_miss_ctrl_if
// Purpose  : L1-miss request, L2 lookup, page-table-walk and response bundle.
//            Perf-counter signals exist only with TLB_L2_MISS_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface tlb_l2_miss_ctrl_if #(
    parameter int ASID_WIDTH = 1,
    parameter int VLEN       = 64
);
    logic                  flush_i;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [VLEN-1:0]       req_vaddr_i;
    logic [ASID_WIDTH-1:0] req_asid_i;

    logic                  l2_access_o;
    logic [VLEN-1:0]       l2_vaddr_o;
    logic [ASID_WIDTH-1:0] l2_asid_o;
    logic                  l2_hit_i;
    logic                  l2_all_checked_i;
    logic [63:0]           l2_content_i;
    logic                  l2_is_2M_i;
    logic                  l2_is_1G_i;

    logic                  ptw_active_o;
    logic                  ptw_valid_o;
    logic                  ptw_ready_i;
    logic [VLEN-1:0]       ptw_vaddr_o;
    logic [ASID_WIDTH-1:0] ptw_asid_o;
    logic                  ptw_done_i;
    logic                  ptw_error_i;
    logic [63:0]           ptw_content_i;
    logic                  ptw_is_2M_i;
    logic                  ptw_is_1G_i;

    logic                  rsp_valid_o;
    logic [63:0]           rsp_content_o;
    logic                  rsp_is_2M_o;
    logic                  rsp_is_1G_o;
    logic                  rsp_error_o;

`ifdef TLB_L2_MISS_CTRL_PERF_EN
    logic [31:0]           l2_hit_cnt_o;
    logic [31:0]           l2_miss_cnt_o;
    logic [15:0]           ptw_timeout_cnt_o;
`endif

    // The miss controller itself
    modport slave (
        input  flush_i, req_valid_i, req_vaddr_i, req_asid_i,
               l2_hit_i, l2_all_checked_i, l2_content_i, l2_is_2M_i, l2_is_1G_i,
               ptw_ready_i, ptw_done_i, ptw_error_i, ptw_content_i,
               ptw_is_2M_i, ptw_is_1G_i,
        output req_ready_o, l2_access_o, l2_vaddr_o, l2_asid_o,
               ptw_active_o, ptw_valid_o, ptw_vaddr_o, ptw_asid_o,
               rsp_valid_o, rsp_content_o, rsp_is_2M_o, rsp_is_1G_o, rsp_error_o
`ifdef TLB_L2_MISS_CTRL_PERF_EN
        , output l2_hit_cnt_o, l2_miss_cnt_o, ptw_timeout_cnt_o
`endif
    );

    // The surrounding L1 / L2 / walker environment
    modport master (
        output flush_i, req_valid_i, req_vaddr_i, req_asid_i,
               l2_hit_i, l2_all_checked_i, l2_content_i, l2_is_2M_i, l2_is_1G_i,
               ptw_ready_i, ptw_done_i, ptw_error_i, ptw_content_i,
               ptw_is_2M_i, ptw_is_1G_i,
        input  req_ready_o, l2_access_o, l2_vaddr_o, l2_asid_o,
               ptw_active_o, ptw_valid_o, ptw_vaddr_o, ptw_asid_o,
               rsp_valid_o, rsp_content_o, rsp_is_2M_o, rsp_is_1G_o, rsp_error_o
`ifdef TLB_L2_MISS_CTRL_PERF_EN
        , input l2_hit_cnt_o, l2_miss_cnt_o, ptw_timeout_cnt_o
`endif
    );
endinterface
`default_nettype wire

// File: rtl/tlb_l2_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tlb_l2_miss_ctrl
// Purpose  : L1-miss sequencer: hash-rehash L2 TLB lookup, then page-table
//            walk with timeout. Optional macro: TLB_L2_MISS_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_l2_miss_ctrl #(
    parameter int ASID_WIDTH  = 1,
    parameter int VLEN        = 64,
    parameter int PTW_TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    tlb_l2_miss_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(PTW_TIMEOUT + 2);
    // Last PTW_WAIT cycle: the incremented count reaches PTW_TIMEOUT-1 here
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((PTW_TIMEOUT >= 2) ? (PTW_TIMEOUT - 2) : 0);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_PTW_REQ  = 3'd2;
    localparam logic [2:0] S_PTW_WAIT = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;

    logic [2:0]            state;
    logic [2:0]            state_next;

    logic [VLEN-1:0]       vaddr_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic [63:0]           pte_q;
    logic                  is_2m_q;
    logic                  is_1g_q;
    logic                  error_q;
    logic [1:0]            probe_q;
    logic [CNT_W-1:0]      tmo_cnt_q;

    logic                  req_ready;
    logic                  l2_access;
    logic                  ptw_valid;
    logic                  ptw_active;
    logic                  rsp_valid;

    logic                  accept;
    logic                  last_probe;
    logic                  tmo_reached;
    logic                  hit_evt;
    logic                  miss_evt;
    logic                  done_evt;
    logic                  tmo_evt;

    // ------------------------------------------------------------------------
    // Event decode shared by the FSM, datapath and perf counters
    // ------------------------------------------------------------------------
    assign accept      = bus.req_valid_i && req_ready;
    // Third probe is final even if the L2 never raises all_checked
    assign last_probe  = bus.l2_all_checked_i || (probe_q == 2'd2);
    assign tmo_reached = (tmo_cnt_q == TMO_LAST);

    assign hit_evt  = (state == S_LOOKUP) && !bus.flush_i && bus.l2_hit_i;
    assign miss_evt = (state == S_LOOKUP) && !bus.flush_i && !bus.l2_hit_i && last_probe;
    assign done_evt = (state == S_PTW_WAIT) && !bus.flush_i && bus.ptw_done_i;
    assign tmo_evt  = (state == S_PTW_WAIT) && !bus.flush_i && !bus.ptw_done_i && tmo_reached;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit_evt)          state_next = S_RESP;
                else if (miss_evt)    state_next = S_PTW_REQ;
                else if (bus.flush_i) state_next = S_IDLE;
            end
            S_PTW_REQ: begin
                if (bus.flush_i)          state_next = S_IDLE;
                else if (bus.ptw_ready_i) state_next = S_PTW_WAIT;
            end
            S_PTW_WAIT: begin
                if (done_evt || tmo_evt) state_next = S_RESP;
                // A flush with done drops the result; without done, drain the walker
                else if (bus.flush_i)    state_next = bus.ptw_done_i ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.ptw_done_i) state_next = S_IDLE;
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        req_ready  = 1'b0;
        l2_access  = 1'b0;
        ptw_valid  = 1'b0;
        ptw_active = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = rst_ni && !bus.flush_i;
            end
            S_LOOKUP: begin
                l2_access = 1'b1;
            end
            S_PTW_REQ: begin
                ptw_valid  = 1'b1;
                ptw_active = 1'b1;
            end
            S_PTW_WAIT, S_DRAIN: begin
                ptw_active = 1'b1;
            end
            S_RESP: begin
                rsp_valid = !bus.flush_i;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch, probe index and walk timeout counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vaddr_q   <= '0;
            asid_q    <= '0;
            probe_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (accept) begin
                vaddr_q <= bus.req_vaddr_i;
                asid_q  <= bus.req_asid_i;
                probe_q <= '0;
            end else if (state == S_LOOKUP) begin
                probe_q <= probe_q + 2'd1;
            end

            if ((state == S_PTW_REQ) && bus.ptw_ready_i) begin
                tmo_cnt_q <= '0;
            end else if (state == S_PTW_WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response registers: loaded only on the transition into RESP
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pte_q   <= '0;
            is_2m_q <= 1'b0;
            is_1g_q <= 1'b0;
            error_q <= 1'b0;
        end else if (hit_evt) begin
            pte_q   <= bus.l2_content_i;
            is_2m_q <= bus.l2_is_2M_i;
            is_1g_q <= bus.l2_is_1G_i;
            error_q <= 1'b0;
        end else if (done_evt) begin
            pte_q   <= bus.ptw_content_i;
            is_2m_q <= bus.ptw_is_2M_i;
            is_1g_q <= bus.ptw_is_1G_i;
            error_q <= bus.ptw_error_i;
        end else if (tmo_evt) begin
            pte_q   <= '0;
            is_2m_q <= 1'b0;
            is_1g_q <= 1'b0;
            error_q <= 1'b1;
        end
    end

    assign bus.req_ready_o   = req_ready;
    assign bus.l2_access_o   = l2_access;
    assign bus.l2_vaddr_o    = vaddr_q;
    assign bus.l2_asid_o     = asid_q;
    assign bus.ptw_active_o  = ptw_active;
    assign bus.ptw_valid_o   = ptw_valid;
    assign bus.ptw_vaddr_o   = vaddr_q;
    assign bus.ptw_asid_o    = asid_q;
    assign bus.rsp_valid_o   = rsp_valid;
    assign bus.rsp_content_o = pte_q;
    assign bus.rsp_is_2M_o   = is_2m_q;
    assign bus.rsp_is_1G_o   = is_1g_q;
    assign bus.rsp_error_o   = error_q;

`ifdef TLB_L2_MISS_CTRL_PERF_EN
    // ------------------------------------------------------------------------
    // Saturating event counters, cleared only by reset
    // ------------------------------------------------------------------------
    logic [31:0] perf_hit_cnt;
    logic [31:0] perf_miss_cnt;
    logic [15:0] perf_tmo_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
            perf_tmo_cnt  <= '0;
        end else begin
            if (hit_evt && (perf_hit_cnt != '1)) begin
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            end
            if (miss_evt && (perf_miss_cnt != '1)) begin
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            end
            if (tmo_evt && (perf_tmo_cnt != '1)) begin
                perf_tmo_cnt <= perf_tmo_cnt + 16'd1;
            end
        end
    end

    assign bus.l2_hit_cnt_o      = perf_hit_cnt;
    assign bus.l2_miss_cnt_o     = perf_miss_cnt;
    assign bus.ptw_timeout_cnt_o = perf_tmo_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlb_l2_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_l2_miss_ctrl
// Purpose  : Directed self-checking bench; two controllers (PTW_TIMEOUT 16 and
//            4) share one stimulus, sel picks the one being observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlb_l2_miss_ctrl;

    localparam int AW = 1;
    localparam int VL = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic [VL-1:0] req_vaddr = '0;
    logic [AW-1:0] req_asid = '0;
    logic          l2_hit = 1'b0;
    logic          l2_all = 1'b0;
    logic [63:0]   l2_content = '0;
    logic          l2_2m = 1'b0;
    logic          l2_1g = 1'b0;
    logic          ptw_ready = 1'b0;
    logic          ptw_done = 1'b0;
    logic          ptw_err = 1'b0;
    logic [63:0]   ptw_content = '0;
    logic          ptw_2m = 1'b0;
    logic          ptw_1g = 1'b0;

    logic [1:0]    rdy, acc, pv, pa, rv, r2m, r1g, rerr;
    logic [63:0]   rcont [2];
    logic [VL-1:0] l2va [2];
    logic [VL-1:0] ptwva [2];
    logic [AW-1:0] l2as [2];

    int sel   = 0;
    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tlb_l2_miss_ctrl_if #(.ASID_WIDTH(AW), .VLEN(VL)) bus ();

        assign bus.flush_i          = flush;
        assign bus.req_valid_i      = req_valid;
        assign bus.req_vaddr_i      = req_vaddr;
        assign bus.req_asid_i       = req_asid;
        assign bus.l2_hit_i         = l2_hit;
        assign bus.l2_all_checked_i = l2_all;
        assign bus.l2_content_i     = l2_content;
        assign bus.l2_is_2M_i       = l2_2m;
        assign bus.l2_is_1G_i       = l2_1g;
        assign bus.ptw_ready_i      = ptw_ready;
        assign bus.ptw_done_i       = ptw_done;
        assign bus.ptw_error_i      = ptw_err;
        assign bus.ptw_content_i    = ptw_content;
        assign bus.ptw_is_2M_i      = ptw_2m;
        assign bus.ptw_is_1G_i      = ptw_1g;

        tlb_l2_miss_ctrl #(
            .ASID_WIDTH  (AW),
            .VLEN        (VL),
            .PTW_TIMEOUT ((g == 0) ? 16 : 4)
        ) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .bus    (bus)
        );

        assign rdy[g]   = bus.req_ready_o;
        assign acc[g]   = bus.l2_access_o;
        assign pv[g]    = bus.ptw_valid_o;
        assign pa[g]    = bus.ptw_active_o;
        assign rv[g]    = bus.rsp_valid_o;
        assign r2m[g]   = bus.rsp_is_2M_o;
        assign r1g[g]   = bus.rsp_is_1G_o;
        assign rerr[g]  = bus.rsp_error_o;
        assign rcont[g] = bus.rsp_content_o;
        assign l2va[g]  = bus.l2_vaddr_o;
        assign ptwva[g] = bus.ptw_vaddr_o;
        assign l2as[g]  = bus.l2_asid_o;
    end

    typedef struct {
        logic [63:0]   vaddr;
        logic [AW-1:0] asid;
        int            probe;
        logic [63:0]   pte;
        logic          is2m;
        logic          is1g;
    } hit_vec_t;

    hit_vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        flush = 1'b0; req_valid = 1'b0; l2_hit = 1'b0; l2_all = 1'b0;
        l2_2m = 1'b0; l2_1g = 1'b0; ptw_ready = 1'b0; ptw_done = 1'b0;
        ptw_err = 1'b0; ptw_2m = 1'b0; ptw_1g = 1'b0;
    endtask

    // Presents a request in cycle T; returns at the start of cycle T+1
    task automatic issue(input logic [63:0] va, input logic [AW-1:0] asid, input string tag);
        req_valid = 1'b1;
        req_vaddr = va;
        req_asid  = asid;
        @(negedge clk);
        check({tag, "_req_ready"}, 64'(rdy[sel]), 64'd1);
        next_cycle();
        req_valid = 1'b0;
    endtask

    task automatic run_hit(input hit_vec_t v, input string tag);
        int          acc_cnt = 0;
        int          lat = 0;
        int          nrsp = 0;
        logic [63:0] cont = '0;
        logic        g2m = 1'b0;
        logic        g1g = 1'b0;
        logic        gerr = 1'b1;
        issue(v.vaddr, v.asid, tag);
        for (int c = 1; c <= 6; c++) begin
            l2_hit     = (c - 1 == v.probe);
            l2_all     = (c - 1 == 2);
            l2_content = (c - 1 == v.probe) ? v.pte : 64'hBAD0_BAD0_BAD0_BAD0;
            l2_2m      = v.is2m;
            l2_1g      = v.is1g;
            @(negedge clk);
            if (acc[sel]) acc_cnt++;
            if (c == 1) begin
                check({tag, "_l2_vaddr"}, l2va[sel], v.vaddr);
                check({tag, "_l2_asid"}, 64'(l2as[sel]), 64'(v.asid));
            end
            if (rv[sel]) begin
                nrsp++;
                lat  = c;
                cont = rcont[sel];
                g2m  = r2m[sel];
                g1g  = r1g[sel];
                gerr = rerr[sel];
            end
            next_cycle();
        end
        quiet_inputs();
        check({tag, "_latency"}, 64'(lat), 64'(2 + v.probe));
        check({tag, "_access_cycles"}, 64'(acc_cnt), 64'(v.probe + 1));
        check({tag, "_rsp_count"}, 64'(nrsp), 64'd1);
        check({tag, "_content"}, cont, v.pte);
        check({tag, "_is_2M"}, 64'(g2m), 64'(v.is2m));
        check({tag, "_is_1G"}, 64'(g1g), 64'(v.is1g));
        check({tag, "_error"}, 64'(gerr), 64'd0);
        check({tag, "_content_held"}, rcont[sel], v.pte);
    endtask

    initial begin
        int nrsp;
        int first_pv;
        int first_rv;
        int pa_cnt;
        logic [63:0] cont;
        logic g2m;
        logic gerr;

        vecs[0] = '{vaddr: 64'h4020_1000, asid: 1'b1, probe: 0, pte: 64'hCF, is2m: 1'b0, is1g: 1'b0};
        vecs[1] = '{vaddr: 64'h7FFF_C000_0000, asid: 1'b0, probe: 2, pte: 64'h2000_00CF, is2m: 1'b0, is1g: 1'b1};
        vecs[2] = '{vaddr: 64'h0000_1234_5000, asid: 1'b1, probe: 1, pte: 64'h0000_0000_0020_00C7, is2m: 1'b1, is1g: 1'b0};
        vecs[3] = '{vaddr: 64'hFFFF_FFFF_FFFF_F000, asid: 1'b0, probe: 0, pte: 64'hFFFF_FFFF_FFFF_FFFF, is2m: 1'b1, is1g: 1'b1};

        // Reset state
        #2;
        check("rst_req_ready", 64'(rdy[0]), 64'd0);
        check("rst_rsp_valid", 64'(rv[0]), 64'd0);
        check("rst_ptw_active", 64'(pa[0]), 64'd0);
        check("rst_rsp_content", rcont[0], 64'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(rdy[0]), 64'd1);
        next_cycle();

        // L2 hits on various probes
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            run_hit(vecs[i], $sformatf("hit%0d", i));
        end

        // Full miss: walker ready in cycle T+6, done in T+11
        issue(64'h0000_0080_0040_2000, 1'b1, "miss");
        nrsp = 0; first_pv = 0; first_rv = 0; pa_cnt = 0; cont = '0; g2m = 0; gerr = 1;
        for (int c = 1; c <= 14; c++) begin
            l2_all      = (c == 3);
            ptw_ready   = (c == 6);
            ptw_done    = (c == 11);
            ptw_content = (c == 11) ? 64'h1001 : 64'h0;
            ptw_2m      = (c == 11);
            @(negedge clk);
            if (pv[0] && first_pv == 0) first_pv = c;
            if (pa[0]) pa_cnt++;
            if (c == 5) check("miss_ptw_vaddr", ptwva[0], 64'h0000_0080_0040_2000);
            if (rv[0]) begin
                nrsp++; first_rv = c; cont = rcont[0]; g2m = r2m[0]; gerr = rerr[0];
            end
            next_cycle();
        end
        quiet_inputs();
        check("miss_first_ptw_valid", 64'(first_pv), 64'd4);
        check("miss_ptw_active_cycles", 64'(pa_cnt), 64'd8);
        check("miss_rsp_cycle", 64'(first_rv), 64'd12);
        check("miss_rsp_count", 64'(nrsp), 64'd1);
        check("miss_content", cont, 64'h1001);
        check("miss_is_2M", 64'(g2m), 64'd1);
        check("miss_error", 64'(gerr), 64'd0);

        // Timeout on the PTW_TIMEOUT=4 instance; late done at T+10
        sel = 1;
        issue(64'h0000_0000_0BAD_0000, 1'b0, "tmo");
        nrsp = 0; first_rv = 0; cont = 64'hFFFF; gerr = 0;
        for (int c = 1; c <= 14; c++) begin
            l2_all      = (c == 3);
            ptw_ready   = (c == 4);
            ptw_done    = (c == 10);
            ptw_content = 64'h5555;
            @(negedge clk);
            if (rv[1]) begin
                nrsp++;
                if (first_rv == 0) begin
                    first_rv = c; cont = rcont[1]; gerr = rerr[1];
                end
            end
            next_cycle();
        end
        quiet_inputs();
        check("tmo_rsp_cycle", 64'(first_rv), 64'd8);
        check("tmo_rsp_count", 64'(nrsp), 64'd1);
        check("tmo_content", cont, 64'd0);
        check("tmo_error", 64'(gerr), 64'd1);

        // Flush during PTW_WAIT, done three cycles later
        issue(64'h0000_0000_00F1_0000, 1'b1, "flw");
        nrsp = 0; pa_cnt = 0;
        for (int c = 1; c <= 11; c++) begin
            l2_all    = (c == 3);
            ptw_ready = (c == 4);
            flush     = (c == 6);
            ptw_done  = (c == 9);
            @(negedge clk);
            if (rv[1]) nrsp++;
            if (c == 9) begin
                check("flw_active_at_done", 64'(pa[1]), 64'd1);
                check("flw_ready_at_done", 64'(rdy[1]), 64'd0);
            end
            if (c == 10) check("flw_ready_after_done", 64'(rdy[1]), 64'd1);
            next_cycle();
        end
        quiet_inputs();
        check("flw_rsp_count", 64'(nrsp), 64'd0);

        // Flush coinciding with an L2 hit: no response, old response held
        issue(64'h0000_0000_0000_3000, 1'b1, "fll");
        nrsp = 0;
        for (int c = 1; c <= 4; c++) begin
            l2_hit     = (c == 1);
            flush      = (c == 1);
            l2_content = 64'hDEAD;
            @(negedge clk);
            if (rv[1]) nrsp++;
            if (c == 2) check("fll_ready_next", 64'(rdy[1]), 64'd1);
            next_cycle();
        end
        quiet_inputs();
        check("fll_rsp_count", 64'(nrsp), 64'd0);
        check("fll_content_held", rcont[1], 64'd0);
        check("fll_error_held", 64'(rerr[1]), 64'd1);

        // Flush in IDLE blocks acceptance
        flush = 1'b1;
        @(negedge clk);
        check("idle_flush_ready", 64'(rdy[1]), 64'd0);
        next_cycle();
        quiet_inputs();

        // Reset during LOOKUP, then a normal request
        sel = 0;
        issue(64'h0000_0000_4020_1000, 1'b1, "rst");
        rst_n = 1'b0;
        #1;
        check("rst_mid_access", 64'(acc[0]), 64'd0);
        check("rst_mid_ready", 64'(rdy[0]), 64'd0);
        check("rst_mid_l2_vaddr", l2va[0], 64'd0);
        check("rst_mid_rsp_content", rcont[0], 64'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        run_hit(vecs[0], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
